avalon_ram_arbiter: RTL and testbench
=====================================

# avalon_ram_arbiter

Two-master, one-slave Avalon-MM arbiter that shares the single `RAM_avalon` port between the CPU instruction-fetch master (m0) and data master (m1). It uses round-robin arbitration and registers the granted command onto the slave port. It also inserts a mandatory idle cycle between slave transactions, so edge-triggered slaves see a fresh rising `read`/`write`. A watchdog aborts any slave transaction that stalls beyond `TIMEOUT` cycles.

## Interface
- `TIMEOUT`, default 16: maximum WAIT-state cycles before abort; legal range 1..65535.
- `ERR_DATA`, default 32'hDEADBEEF: readdata returned to a master whose read was aborted.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_address`, `m1_address` in 32: master byte address.
- `m0_read`, `m1_read` / `m0_write`, `m1_write` in 1 each: Avalon command strobes.
- `m0_byteenable`, `m1_byteenable` in 4: byte lanes.
- `m0_writedata`, `m1_writedata` in 32: write data.
- `m0_waitrequest`, `m1_waitrequest` out 1: stall to master.
- `m0_readdata`, `m1_readdata` out 32: read data to master.
- `s_address` out 32, `s_byteenable` out 4, `s_writedata` out 32, `s_read` out 1, `s_write` out 1: registered slave command.
- `s_waitrequest` in 1, `s_readdata` in 32: slave response.
- `grant` out 2: one-hot owner of current transaction (00 when idle).
- `bus_error` out 1: sticky, set on any timeout.

## Operation
- **Request:** a master requests when `read|write` is high. Masters hold command and operands stable until their waitrequest is low (Avalon rule). Read and write both high from one master is treated as a write.
- **FSM states:** IDLE, ISSUE, WAIT, GAP.
- **IDLE:** if any request is present, pick the winner and latch its address, byteenable, writedata and direction into the slave registers; go to ISSUE. Otherwise stay in IDLE.
- **Arbitration:** round-robin on a 1-bit `last` pointer. When both masters request, the master that was not granted last wins. A single requester always wins. `last` updates at grant. It resets to 1, so m0 wins the first contention.
- **ISSUE:** `s_read`/`s_write` high. `s_waitrequest` is ignored this cycle. Unconditionally go to WAIT and clear the watchdog counter.
- **WAIT:** command held.
  - If `s_waitrequest` is 0, this is the completion cycle. Go to GAP.
  - Else, if the counter has reached `TIMEOUT`-1, this is the abort cycle. Set `bus_error` and go to GAP.
  - Else, increment the counter.
- **GAP:** `s_read`, `s_write` and `grant` are 0. Always go to IDLE.
- **Master waitrequest:** `mX_waitrequest` is combinational. It is 1 whenever mX `read|write` is high, except in mX's completion or abort cycle, where it is 0. It is 0 when mX is not requesting.
- **Master readdata:**
  - In mX's read completion cycle, `mX_readdata` = `s_readdata` (pass-through).
  - In a read abort cycle, `mX_readdata` = `ERR_DATA`.
  - At that clock edge the value is captured into a per-master hold register, which drives `mX_readdata` at all other times.
- **Writes:** data is not returned. An aborted write is dropped, and the master is still released.
- `bus_error` is cleared only by `reset`.

## Timing
- **Reset values:** state IDLE; `s_read`=`s_write`=0; `s_address`=`s_writedata`=0; `s_byteenable`=0; `grant`=00; `bus_error`=0; hold registers 0; `last`=1. `reset` mid-transaction aborts without completing the master. The master's waitrequest then follows the IDLE rule.
- **Latency:** request in IDLE at cycle N gives ISSUE at N+1 and WAIT from N+2. Completion occurs at the first WAIT cycle with `s_waitrequest`=0, then GAP, then IDLE.
- **Minimum occupancy:** 4 cycles per transaction (IDLE, ISSUE, WAIT, GAP).
- **Back-to-back:** a pending second request is granted in the IDLE following GAP. `s_read`/`s_write` are always low for at least 2 consecutive cycles (GAP and IDLE) between transactions.
- **Abort:** occurs in the `TIMEOUT`th WAIT cycle. The counter is 16 bits and saturates, with no wrap.
- **Late arrival:** a request arriving during ISSUE, WAIT or GAP waits for IDLE. The losing master sees waitrequest=1 throughout.

## Test plan
- **Single read:** reset, then m0 reads 0xBFC00000 against `RAM_avalon` (4-cycle wait) with word 0 = 0x00211021. Required: `m0_readdata`=0x00211021 in the completion cycle, `grant`=01 during ISSUE and WAIT, and `s_read` low in GAP.
- **Contention:** m0 and m1 both read in the same cycle after reset. m0 is served first, then m1. A second simultaneous pair is served m1 first, then m0. `s_read` is low for 2 cycles between each pair of transactions.
- **Write then read:** m1 writes 0xCAFEF00D to 0xBFC00010, then m0 reads 0xBFC00010. Required: m0 receives 0xCAFEF00D, and m1 waitrequest drops exactly in the write completion cycle.
- **Timeout:** the slave holds `s_waitrequest`=1 forever with `TIMEOUT`=16. Required: m0 read is released in the 16th WAIT cycle with readdata 0xDEADBEEF, `bus_error`=1 sticky, and a following normal read succeeds.
- **Reset mid-WAIT:** assert `reset` for 1 cycle during WAIT. Next cycle: state IDLE, `s_read`=0, `grant`=00, `bus_error`=0. A held request is re-granted afterwards.
- **Zero-wait slave:** `s_waitrequest` is tied low. Required: completion in the first WAIT cycle, and 4-cycle occupancy per transaction.

Source files
------------

// File: rtl/avalon_ram_arbiter.sv
// Two-master round-robin arbiter onto a single Avalon-MM slave port, with a
// registered slave command, a forced idle gap between transfers and a stall watchdog.
module avalon_ram_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic [3:0]  s_byteenable,
  output logic [31:0] s_writedata,
  output logic        s_read,
  output logic        s_write,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [15:0] cnt;
  logic [31:0] hold0;
  logic [31:0] hold1;

  logic        req0;
  logic        req1;
  logic        req_any;
  logic        pick1;
  logic        wr_sel;
  logic        timeout_hit;
  logic        done;
  logic        abort;
  logic [31:0] rd_val;

  assign req0        = m0_read | m0_write;
  assign req1        = m1_read | m1_write;
  assign req_any     = req0 | req1;
  // m1 wins when alone, or on contention when m0 held the previous grant
  assign pick1       = req1 & (~req0 | ~last);
  assign wr_sel      = pick1 ? m1_write : m0_write;
  assign timeout_hit = (cnt == TO_LAST);
  assign done        = (state == ST_WAIT) & (~s_waitrequest | timeout_hit);
  assign abort       = (state == ST_WAIT) & s_waitrequest & timeout_hit;
  assign rd_val      = abort ? ERR_DATA : s_readdata;

  assign m0_waitrequest = req0 & ~(done & grant[0]);
  assign m1_waitrequest = req1 & ~(done & grant[1]);
  assign m0_readdata    = (done & s_read & grant[0]) ? rd_val : hold0;
  assign m1_readdata    = (done & s_read & grant[1]) ? rd_val : hold1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_any) state_nxt = ST_ISSUE;
        else         state_nxt = ST_IDLE;
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done) state_nxt = ST_GAP;
        else      state_nxt = ST_WAIT;
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      last         <= 1'b1;
      cnt          <= 16'd0;
      hold0        <= 32'd0;
      hold1        <= 32'd0;
      s_address    <= 32'd0;
      s_byteenable <= 4'd0;
      s_writedata  <= 32'd0;
      s_read       <= 1'b0;
      s_write      <= 1'b0;
      grant        <= 2'b00;
      bus_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            s_address    <= pick1 ? m1_address    : m0_address;
            s_byteenable <= pick1 ? m1_byteenable : m0_byteenable;
            s_writedata  <= pick1 ? m1_writedata  : m0_writedata;
            s_read       <= ~wr_sel;
            s_write      <= wr_sel;
            grant        <= pick1 ? 2'b10 : 2'b01;
            last         <= pick1;
          end
        end
        ST_ISSUE: cnt <= 16'd0;
        ST_WAIT: begin
          if (done) begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
            grant   <= 2'b00;
            if (abort) bus_error <= 1'b1;
            if (s_read && grant[0]) hold0 <= rd_val;
            if (s_read && grant[1]) hold1 <= rd_val;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// Directed bench for avalon_ram_arbiter with a small RAM slave model whose
// wait states, permanent stall and zero-wait behaviour are controlled per step.
module tb_avalon_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write, s_waitrequest;
  logic [1:0]  grant;
  logic        bus_error;

  int tests = 0;
  int fails = 0;

  // Slave model: stalls while fewer than lat cycles of command have elapsed
  logic [31:0] mem [0:15];
  int          busy_cnt = 0;
  int          lat = 5;
  logic        stall = 1'b0;
  logic        zero_wait = 1'b0;

  assign s_waitrequest = zero_wait ? 1'b0 : (stall | (busy_cnt < lat));
  assign s_readdata    = mem[s_address[5:2]];

  always @(posedge clk) begin
    if (s_read | s_write) busy_cnt <= busy_cnt + 1;
    else                  busy_cnt <= 0;
    if (s_write && !s_waitrequest) mem[s_address[5:2]] <= s_writedata;
  end

  always #5 clk = ~clk;

  avalon_ram_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .grant(grant), .bus_error(bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic wreq(input int m);
    return (m == 0) ? m0_waitrequest : m1_waitrequest;
  endfunction

  function automatic logic [31:0] rdata(input int m);
    return (m == 0) ? m0_readdata : m1_readdata;
  endfunction

  task automatic set_m(input int m, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr;
      m0_writedata = wdata; m0_byteenable = 4'hF;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr;
      m1_writedata = wdata; m1_byteenable = 4'hF;
    end
  endtask

  // One transaction from IDLE; returns in the IDLE cycle after GAP
  task automatic do_txn(input int m, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input int exp_n, input string tag);
    int   n;
    logic rel;
    set_m(m, !wr, wr, addr, wdata);
    #1;
    chk({tag, " wreq_idle"}, 32'(wreq(m)), 32'd1);
    cyc;
    chk({tag, " grant_issue"}, 32'(grant), (m == 0) ? 32'd1 : 32'd2);
    chk({tag, " cmd_issue"}, 32'(wr ? s_write : s_read), 32'd1);
    chk({tag, " addr_issue"}, s_address, addr);
    n = 0;
    rel = 1'b0;
    while (!rel && n < 40) begin
      cyc;
      n++;
      if (!wreq(m)) rel = 1'b1;
    end
    chk({tag, " release_cycle"}, 32'(n), 32'(exp_n));
    chk({tag, " grant_done"}, 32'(grant), (m == 0) ? 32'd1 : 32'd2);
    if (!wr) chk({tag, " rdata_done"}, rdata(m), exp_rd);
    cyc;
    set_m(m, 1'b0, 1'b0, addr, wdata);
    #1;
    chk({tag, " gap_cmd"}, {28'd0, s_read, s_write, grant}, 32'd0);
    if (!wr) chk({tag, " rdata_hold"}, rdata(m), exp_rd);
    cyc;
    chk({tag, " idle_cmd"}, {30'd0, s_read, s_write}, 32'd0);
  endtask

  // Both masters read simultaneously; checks service order and 2-cycle gap
  task automatic pair(input int exp_first, input string tag);
    int   k, lowrun, cycles;
    logic seen_high, done0, done1, pend0, pend1;
    int   ord [0:1];
    k = 0; lowrun = 0; cycles = 0;
    seen_high = 1'b0; done0 = 1'b0; done1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
    ord[0] = -1; ord[1] = -1;
    set_m(0, 1'b1, 1'b0, 32'hBFC00000, 32'd0);
    set_m(1, 1'b1, 1'b0, 32'hBFC00004, 32'd0);
    #1;
    while (!(done0 && done1) && cycles < 80) begin
      if (m0_read && !m0_waitrequest && k < 2) begin
        ord[k] = 0; k++; pend0 = 1'b1;
        chk({tag, " m0_rdata"}, m0_readdata, 32'h00211021);
      end
      if (m1_read && !m1_waitrequest && k < 2) begin
        ord[k] = 1; k++; pend1 = 1'b1;
        chk({tag, " m1_rdata"}, m1_readdata, 32'h10000001);
      end
      if (s_read) begin
        if (seen_high && lowrun > 0) chk({tag, " gap_len"}, 32'(lowrun), 32'd2);
        lowrun = 0;
        seen_high = 1'b1;
      end else begin
        lowrun++;
      end
      cyc;
      cycles++;
      if (pend0) begin m0_read = 1'b0; pend0 = 1'b0; done0 = 1'b1; end
      if (pend1) begin m1_read = 1'b0; pend1 = 1'b0; done1 = 1'b1; end
      #1;
    end
    chk({tag, " both_done"}, {30'd0, done0, done1}, 32'd3);
    chk({tag, " first"}, 32'(ord[0]), 32'(exp_first));
    chk({tag, " second"}, 32'(ord[1]), 32'(1 - exp_first));
    cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 32'h10000000 + 32'(i);
    mem[0] = 32'h00211021;
    reset = 1'b1;
    set_m(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc; cyc;
    chk("rst s_cmd", {30'd0, s_read, s_write}, 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst bus_error", 32'(bus_error), 32'd0);
    chk("rst s_address", s_address, 32'd0);
    chk("rst m0_readdata", m0_readdata, 32'd0);
    chk("rst m0_wreq", 32'(m0_waitrequest), 32'd0);
    reset = 1'b0;
    cyc;

    // Single read with 4 wait states: completion in the 5th WAIT cycle
    do_txn(0, 1'b0, 32'hBFC00000, 32'd0, 32'h00211021, 5, "single_rd");

    // Contention from reset: m0 first; after an m0-only grant, m1 first
    reset = 1'b1; cyc; reset = 1'b0; cyc;
    pair(0, "pair_a");
    do_txn(0, 1'b0, 32'hBFC00000, 32'd0, 32'h00211021, 5, "solo_m0");
    pair(1, "pair_b");

    // Write then read back
    do_txn(1, 1'b1, 32'hBFC00010, 32'hCAFEF00D, 32'd0, 5, "wr_m1");
    do_txn(0, 1'b0, 32'hBFC00010, 32'd0, 32'hCAFEF00D, 5, "rd_back");

    // Permanent stall: abort in the 16th WAIT cycle
    stall = 1'b1;
    do_txn(0, 1'b0, 32'hBFC00004, 32'd0, 32'hDEADBEEF, 16, "timeout");
    chk("timeout bus_error", 32'(bus_error), 32'd1);
    stall = 1'b0;
    do_txn(0, 1'b0, 32'hBFC00000, 32'd0, 32'h00211021, 5, "after_to");
    chk("sticky bus_error", 32'(bus_error), 32'd1);

    // Reset during WAIT, request held throughout
    stall = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'hBFC00000, 32'd0);
    cyc; cyc; cyc;
    chk("midrst in_wait", {30'd0, s_read, grant[0]}, 32'd3);
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    #1;
    chk("midrst s_read", 32'(s_read), 32'd0);
    chk("midrst grant", 32'(grant), 32'd0);
    chk("midrst bus_error", 32'(bus_error), 32'd0);
    chk("midrst m0_wreq", 32'(m0_waitrequest), 32'd1);
    stall = 1'b0;
    cyc;
    chk("midrst regrant", 32'(grant), 32'd1);
    n = 0;
    while (m0_waitrequest && n < 40) begin
      cyc;
      n++;
    end
    chk("midrst release", 32'(n), 32'd5);
    chk("midrst rdata", m0_readdata, 32'h00211021);
    cyc;
    set_m(0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc;

    // Zero-wait slave: completion in first WAIT cycle
    zero_wait = 1'b1;
    do_txn(0, 1'b0, 32'hBFC00000, 32'd0, 32'h00211021, 1, "zw_m0");
    do_txn(1, 1'b0, 32'hBFC00004, 32'd0, 32'h10000001, 1, "zw_m1");
    pair(0, "zw_pair");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
